eb_rr_merge: RTL and testbench

- N-input to 1-output stream merger for the valid/ready elastic-buffer fabric.
- Shares one 2-entry elastic buffer stage between N_T requesters.
- A round-robin arbiter picks one valid input per cycle and pushes its data into the buffer.
- The buffer output carries the winning data plus the source index. It sits upstream of any single-consumer elastic pipeline.

---
 rtl/eb_pkg.sv | 18 +
 rtl/eb_rr_arb.sv | 57 +++++
 rtl/eb_rr_merge.sv | 92 +++++++++
 tb/tb_eb_rr_merge.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eb_pkg.sv
// Shared helpers and types for the valid/ready elastic-buffer fabric.
package eb_pkg;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int EB_DEF_N_T      = 4;
    localparam int EB_DEF_T_WIDTH  = 8;
    localparam int EB_DEF_ID_WIDTH = id_width(EB_DEF_N_T);

    // Buffered entry at the default fabric widths: payload plus source index.
    typedef struct packed {
        logic [EB_DEF_T_WIDTH-1:0]  data;
        logic [EB_DEF_ID_WIDTH-1:0] id;
    } eb_entry_t;

endpackage

// File: rtl/eb_rr_arb.sv
// Round-robin arbiter: rotating-priority search from ptr, one-hot t_ready, ptr register.
module eb_rr_arb
    import eb_pkg::*;
#(
    parameter  int N_T      = 4,
    localparam int ID_WIDTH = id_width(N_T)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_T-1:0]      t_valid,
    input  logic                full,
    input  logic                push,
    output logic [ID_WIDTH-1:0] grant,
    output logic [N_T-1:0]      t_ready
);

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [N_T-1:0]      rot;
    logic [ID_WIDTH:0]   sum;
    logic                found;

    // Rotate so that bit 0 is the requester at ptr; the first set bit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rot   = N_T'({t_valid, t_valid} >> ptr_q);
        grant = '0;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < N_T; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
                if (sum >= (ID_WIDTH+1)'(N_T)) sum = sum - (ID_WIDTH+1)'(N_T);
                grant = sum[ID_WIDTH-1:0];
            end
        end
    end

    // Ready is held low throughout reset even with requests pending.
    always_comb begin
        for (int k = 0; k < N_T; k++) begin
            t_ready[k] = found && (grant == ID_WIDTH'(k)) && t_valid[k] && !full && !reset;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (push) ptr_d = (grant == ID_WIDTH'(N_T-1)) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/eb_rr_merge.sv
// N-to-1 round-robin stream merger feeding a shared 2-entry (head + skid) elastic buffer.
module eb_rr_merge
    import eb_pkg::*;
#(
    parameter  int N_T      = 4,
    parameter  int T_WIDTH  = 8,
    localparam int ID_WIDTH = id_width(N_T)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_T*T_WIDTH-1:0] t_data,
    input  logic [N_T-1:0]         t_valid,
    output logic [N_T-1:0]         t_ready,
    output logic [T_WIDTH-1:0]     i_0_data,
    output logic [ID_WIDTH-1:0]    i_0_id,
    output logic                   i_0_valid,
    input  logic                   i_0_ready
);

    typedef struct packed {
        logic [T_WIDTH-1:0]  data;
        logic [ID_WIDTH-1:0] id;
    } entry_t;

    logic [1:0]          count_q, count_d;
    entry_t              head_q, skid_q, new_entry;
    logic [ID_WIDTH-1:0] grant;
    logic                full, push, pop;
    logic                head_en, head_sel_skid, skid_en;

    assign full = (count_q == 2'd2);
    assign push = |t_ready;
    assign pop  = i_0_valid & i_0_ready;

    eb_rr_arb #(.N_T(N_T)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .t_valid (t_valid),
        .full    (full),
        .push    (push),
        .grant   (grant),
        .t_ready (t_ready)
    );

    always_comb begin
        new_entry.data = '0;
        new_entry.id   = grant;
        for (int k = 0; k < N_T; k++) begin
            if (grant == ID_WIDTH'(k)) new_entry.data = t_data[k*T_WIDTH +: T_WIDTH];
        end
    end

    // Control: count update plus load enables and the head source select.
    always_comb begin
        count_d       = count_q;
        head_en       = 1'b0;
        head_sel_skid = 1'b0;
        skid_en       = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                head_en = (count_q == 2'd0);
                skid_en = (count_q == 2'd1);
            end
            2'b01: begin
                count_d       = count_q - 2'd1;
                head_en       = full;
                head_sel_skid = 1'b1;
            end
            2'b11:   head_en = 1'b1;   // only reachable with one entry held
            default: ;
        endcase
    end

    // Data: the head and skid registers are cleared on reset so outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            if (head_en) head_q <= head_sel_skid ? skid_q : new_entry;
            if (skid_en) skid_q <= new_entry;
        end
    end

    assign i_0_valid = (count_q != 2'd0);
    assign i_0_data  = head_q.data;
    assign i_0_id    = head_q.id;

endmodule

// File: tb/tb_eb_rr_merge.sv
// Self-checking bench for eb_rr_merge: directed scenarios plus a queue-based reference model.
module tb_eb_rr_merge;
    import eb_pkg::*;

    localparam int N  = EB_DEF_N_T;
    localparam int W  = EB_DEF_T_WIDTH;
    localparam int IW = EB_DEF_ID_WIDTH;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic [N*W-1:0] t_data    = '0;
    logic [N-1:0]   t_valid   = '0;
    logic [N-1:0]   t_ready;
    logic [W-1:0]   i_0_data;
    logic [IW-1:0]  i_0_id;
    logic           i_0_valid;
    logic           i_0_ready = 1'b0;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: a FIFO of up to two entries and a round-robin pointer.
    eb_entry_t mq[$];
    int        m_ptr = 0;

    always #5 clk = ~clk;

    eb_rr_merge #(.N_T(N), .T_WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .t_data    (t_data),
        .t_valid   (t_valid),
        .t_ready   (t_ready),
        .i_0_data  (i_0_data),
        .i_0_id    (i_0_id),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready)
    );

    // Winner = valid requester with the smallest rotating distance from the pointer.
    function automatic int m_winner();
        int best, best_d, d;
        best   = -1;
        best_d = N;
        for (int k = 0; k < N; k++) begin
            d = (k - m_ptr + N) % N;
            if (t_valid[k] && d < best_d) begin
                best   = k;
                best_d = d;
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = m_winner();
        if (!reset && w >= 0 && mq.size() < 2) r[w] = 1'b1;
        return r;
    endfunction

    task automatic set_data(input int k, input logic [W-1:0] v);
        t_data[k*W +: W] = v;
    endtask

    // Advance the model with the pre-edge inputs, then cross one rising edge.
    task automatic tick(output logic [N-1:0] acc);
        eb_entry_t e;
        int w;
        acc = m_ready();
        w   = m_winner();
        if (mq.size() > 0 && i_0_ready && !reset) void'(mq.pop_front());
        if (acc != '0) begin
            e.data = t_data[w*W +: W];
            e.id   = IW'(w);
            mq.push_back(e);
            m_ptr = (w + 1) % N;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        t_valid   = '0;
        i_0_ready = 1'b0;
        mq.delete();
        m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [N-1:0] acc;
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        reset     = 1'b1;
        t_valid   = '1;
        i_0_ready = 1'b1;
        mq.delete();
        m_ptr = 0;
        for (int k = 0; k < N; k++) set_data(k, W'(8'h10 + k));
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (t_ready !== '0 || i_0_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: got t_ready=%b i_0_valid=%b, want 0000 0", t_ready, i_0_valid);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            tests_run++;
            if (i_0_valid !== 1'b1 || i_0_id !== IW'(exp_ids[i]) || i_0_data !== W'(8'h10 + exp_ids[i])) begin
                tests_failed++;
                $display("FAIL reset_rr_order[%0d]: got valid=%b id=%0d data=%h, want 1 id=%0d data=%h",
                         i, i_0_valid, i_0_id, i_0_data, exp_ids[i], 8'h10 + exp_ids[i]);
            end
        end
    endtask

    task automatic test_single_stream();
        logic [N-1:0] acc;
        apply_reset();
        t_valid   = 4'b0100;
        set_data(2, 8'hA5);
        i_0_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (t_ready !== 4'b0100) begin
                tests_failed++;
                $display("FAIL single_ready[%0d]: got %b, want 0100", i, t_ready);
            end
            tick(acc);
            tests_run++;
            if (i_0_valid !== 1'b1 || i_0_data !== 8'hA5 || i_0_id !== IW'(2)) begin
                tests_failed++;
                $display("FAIL single_out[%0d]: got valid=%b id=%0d data=%h, want 1 id=2 data=a5",
                         i, i_0_valid, i_0_id, i_0_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] acc;
        logic [W-1:0] seq[3] = '{8'h11, 8'h22, 8'h33};
        apply_reset();
        t_valid = 4'b0011;
        set_data(0, 8'h11);
        set_data(1, 8'h22);
        #1;
        tests_run++;
        if (t_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_first_grant: got %b, want 0001", t_ready);
        end
        tick(acc);
        t_valid[0] = 1'b0;
        #1;
        tests_run++;
        if (t_ready !== 4'b0010 || i_0_data !== 8'h11) begin
            tests_failed++;
            $display("FAIL bp_second_grant: got ready=%b data=%h, want 0010 11", t_ready, i_0_data);
        end
        tick(acc);
        t_valid = 4'b0001;
        set_data(0, 8'h33);
        #1;
        repeat (2) begin
            tests_run++;
            if (t_ready !== 4'b0000 || i_0_valid !== 1'b1 || i_0_data !== 8'h11 || i_0_id !== IW'(0)) begin
                tests_failed++;
                $display("FAIL bp_full_stall: got ready=%b valid=%b id=%0d data=%h, want 0000 1 id=0 data=11",
                         t_ready, i_0_valid, i_0_id, i_0_data);
            end
            tick(acc);
        end
        i_0_ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (i_0_valid !== 1'b1 || i_0_data !== seq[i]) begin
                tests_failed++;
                $display("FAIL bp_drain[%0d]: got valid=%b data=%h, want 1 %h", i, i_0_valid, i_0_data, seq[i]);
            end
            tick(acc);
            if (acc[0]) t_valid[0] = 1'b0;
            #1;
        end
        tests_run++;
        if (i_0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: got valid=%b, want 0", i_0_valid);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] acc;
        apply_reset();
        i_0_ready = 1'b1;
        t_valid   = 4'b0100;
        set_data(2, 8'h42);
        #1;
        tick(acc);
        t_valid = 4'b1001;
        set_data(0, 8'hC0);
        set_data(3, 8'hD3);
        #1;
        tests_run++;
        if (t_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_grant3: got %b, want 1000", t_ready);
        end
        tick(acc);
        t_valid[3] = 1'b0;
        #1;
        tests_run++;
        if (i_0_id !== IW'(3) || i_0_data !== 8'hD3 || t_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wrap_out3: got id=%0d data=%h ready=%b, want id=3 data=d3 ready=0001",
                     i_0_id, i_0_data, t_ready);
        end
        tick(acc);
        tests_run++;
        if (i_0_valid !== 1'b1 || i_0_id !== IW'(0) || i_0_data !== 8'hC0) begin
            tests_failed++;
            $display("FAIL wrap_out0: got valid=%b id=%0d data=%h, want 1 id=0 data=c0",
                     i_0_valid, i_0_id, i_0_data);
        end
    endtask

    task automatic test_async_reset();
        logic [N-1:0] acc;
        apply_reset();
        t_valid = 4'b0110;
        set_data(1, 8'h5A);
        set_data(2, 8'h6B);
        #1;
        tick(acc);
        t_valid[1] = 1'b0;
        #1;
        tick(acc);
        t_valid = '0;
        #1;
        tests_run++;
        if (i_0_valid !== 1'b1 || i_0_data !== 8'h5A) begin
            tests_failed++;
            $display("FAIL areset_prefill: got valid=%b data=%h, want 1 5a", i_0_valid, i_0_data);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (i_0_valid !== 1'b0 || t_ready !== '0) begin
            tests_failed++;
            $display("FAIL areset_async_drop: got valid=%b ready=%b, want 0 0000", i_0_valid, t_ready);
        end
        mq.delete();
        m_ptr = 0;
        @(negedge clk);
        reset     = 1'b0;
        t_valid   = 4'b1000;
        set_data(3, 8'h77);
        i_0_ready = 1'b1;
        #1;
        tests_run++;
        if (t_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL areset_grant: got %b, want 1000", t_ready);
        end
        tick(acc);
        t_valid = '0;
        #1;
        tests_run++;
        if (i_0_valid !== 1'b1 || i_0_data !== 8'h77 || i_0_id !== IW'(3)) begin
            tests_failed++;
            $display("FAIL areset_fresh: got valid=%b id=%0d data=%h, want 1 id=3 data=77",
                     i_0_valid, i_0_id, i_0_data);
        end
        tick(acc);
        tests_run++;
        if (i_0_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_no_stale: got valid=%b data=%h, want 0", i_0_valid, i_0_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] acc, exp_r;
        eb_entry_t    exp_e;
        apply_reset();
        i_0_ready = 1'b1;
        t_valid   = '1;
        for (int k = 0; k < N; k++) set_data(k, 8'($urandom));
        #1;
        for (int c = 0; c < 40; c++) begin
            exp_r = m_ready();
            exp_e = (mq.size() > 0) ? mq[0] : '0;
            tests_run++;
            if (t_ready !== exp_r || t_ready === '0 || i_0_valid !== (mq.size() > 0)
                || (mq.size() > 0 && (i_0_data !== exp_e.data || i_0_id !== exp_e.id))) begin
                tests_failed++;
                $display("FAIL b2b_model cyc=%0d: got ready=%b valid=%b id=%0d data=%h, want ready=%b valid=%0d id=%0d data=%h",
                         c, t_ready, i_0_valid, i_0_id, i_0_data, exp_r, mq.size() > 0, exp_e.id, exp_e.data);
            end
            if (c > 0) begin
                tests_run++;
                if (i_0_id !== IW'((c - 1) % N)) begin
                    tests_failed++;
                    $display("FAIL b2b_rr_order cyc=%0d: got id=%0d, want %0d", c, i_0_id, (c - 1) % N);
                end
            end
            tick(acc);
            for (int k = 0; k < N; k++) if (acc[k]) set_data(k, 8'($urandom));
            #1;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] acc, exp_r;
        eb_entry_t    exp_e;
        apply_reset();
        #1;
        for (int c = 0; c < 400; c++) begin
            exp_r = m_ready();
            exp_e = (mq.size() > 0) ? mq[0] : '0;
            tests_run++;
            if (t_ready !== exp_r || i_0_valid !== (mq.size() > 0)
                || (mq.size() > 0 && (i_0_data !== exp_e.data || i_0_id !== exp_e.id))) begin
                tests_failed++;
                $display("FAIL random_model cyc=%0d: got ready=%b valid=%b id=%0d data=%h, want ready=%b valid=%0d id=%0d data=%h",
                         c, t_ready, i_0_valid, i_0_id, i_0_data, exp_r, mq.size() > 0, exp_e.id, exp_e.data);
            end
            tick(acc);
            for (int k = 0; k < N; k++) begin
                if (acc[k] || !t_valid[k]) begin
                    t_valid[k] = ($urandom_range(0, 2) != 0);
                    set_data(k, 8'($urandom));
                end
            end
            i_0_ready = ($urandom_range(0, 3) != 0);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
